// File: rtl/io_flag_controller_pkg.sv
// Shared types and defaults for the keyboard/VGA flag controller.
package io_flag_controller_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned ERR_W           = 3;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_OUT_TIMEOUT = 4096;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_BUSY = 1'b1
  } out_state_e;

  // Sticky error flags; packing order gives overflow at bit 0
  typedef struct packed {
    logic timeout;
    logic out_busy;
    logic overflow;
  } err_flags_t;

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module io_sync_edge (
  input  logic clock,
  input  logic clr_n,
  input  logic async_in,
  output logic evt_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // One-cycle pulse per rising edge of the synchronised level
  assign evt_c = sync_q & ~prev_q;

endmodule

// File: rtl/io_flag_controller.sv
// Keyboard FIFO (INPR/FGI), timed display handshake (OUTR/FGO) and IEN/interrupt request
// between the CPU control unit and io_interface.
module io_flag_controller
  import io_flag_controller_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned OUT_TIMEOUT = DEF_OUT_TIMEOUT
) (
  input  logic              clock,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] kbd_data,
  input  logic              kbd_arrived,
  input  logic              vga_went,
  input  logic              cpu_inp,
  input  logic              cpu_out,
  input  logic              cpu_ion,
  input  logic              cpu_iof,
  input  logic              cpu_int_ack,
  input  logic [DATA_W-1:0] cpu_ac,
  output logic [DATA_W-1:0] inpr,
  output logic [DATA_W-1:0] outr,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              int_req,
  output logic [ERR_W-1:0]  err_flags
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMR_W = $clog2(OUT_TIMEOUT);

  logic kbd_evt;
  logic went_evt;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic              fgi_q, fgi_d;

  out_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic              fgo_q, fgo_d;

  logic              ien_q, ien_d;
  logic              int_req_q, int_req_d;
  err_flags_t        err_q, err_d;

  logic fifo_full_c;
  logic push_ok_c;
  logic pop_ok_c;
  logic ovf_c;
  logic busy_err_c;
  logic tmo_c;
  logic ien_clr_c;

  io_sync_edge u_kbd_sync (
    .clock    (clock),
    .clr_n    (clr_n),
    .async_in (kbd_arrived),
    .evt_c    (kbd_evt)
  );

  io_sync_edge u_went_sync (
    .clock    (clock),
    .clr_n    (clr_n),
    .async_in (vga_went),
    .evt_c    (went_evt)
  );

  // A push into a full FIFO still lands when a pop frees the head slot in the same cycle
  always_comb begin
    fifo_full_c = (cnt_q == CNT_W'(FIFO_DEPTH));
    pop_ok_c    = cpu_inp && (cnt_q != '0);
    push_ok_c   = kbd_evt && (!fifo_full_c || pop_ok_c);
    ovf_c       = kbd_evt && fifo_full_c && !pop_ok_c;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = kbd_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok_c && !pop_ok_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push_ok_c && pop_ok_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    inpr_d = mem_d[rd_ptr_d];
    fgi_d  = (cnt_d != '0);
  end

  // Output handshake: a simultaneous went_evt and timeout counts as normal completion
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    outr_d     = outr_q;
    fgo_d      = fgo_q;
    busy_err_c = 1'b0;
    tmo_c      = 1'b0;
    case (state_q)
      O_IDLE: begin
        fgo_d = 1'b1;
        if (cpu_out) begin
          outr_d  = cpu_ac;
          fgo_d   = 1'b0;
          timer_d = '0;
          state_d = O_BUSY;
        end
      end
      O_BUSY: begin
        fgo_d      = 1'b0;
        timer_d    = timer_q + TMR_W'(1);
        busy_err_c = cpu_out;
        if (went_evt) begin
          fgo_d   = 1'b1;
          timer_d = '0;
          state_d = O_IDLE;
        end else if (timer_q == TMR_W'(OUT_TIMEOUT - 1)) begin
          fgo_d   = 1'b1;
          timer_d = '0;
          tmo_c   = 1'b1;
          state_d = O_IDLE;
        end
      end
      default: begin
        state_d = O_IDLE;
      end
    endcase
  end

  // Any IEN clear beats a same-cycle set and drops int_req on the same edge
  always_comb begin
    ien_clr_c = cpu_iof || cpu_int_ack;
    ien_d     = ien_q;
    int_req_d = ien_q && (fgi_q || fgo_q);
    if (ien_clr_c) begin
      ien_d     = 1'b0;
      int_req_d = 1'b0;
    end else if (cpu_ion) begin
      ien_d = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (ovf_c) begin
      err_d.overflow = 1'b1;
    end
    if (busy_err_c) begin
      err_d.out_busy = 1'b1;
    end
    if (tmo_c) begin
      err_d.timeout = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      inpr_q    <= '0;
      fgi_q     <= 1'b0;
      state_q   <= O_IDLE;
      timer_q   <= '0;
      outr_q    <= '0;
      fgo_q     <= 1'b1;
      ien_q     <= 1'b0;
      int_req_q <= 1'b0;
      err_q     <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      inpr_q    <= inpr_d;
      fgi_q     <= fgi_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      outr_q    <= outr_d;
      fgo_q     <= fgo_d;
      ien_q     <= ien_d;
      int_req_q <= int_req_d;
      err_q     <= err_d;
    end
  end

  assign inpr      = inpr_q;
  assign outr      = outr_q;
  assign fgi       = fgi_q;
  assign fgo       = fgo_q;
  assign ien       = ien_q;
  assign int_req   = int_req_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_io_flag_controller.sv
// Vector/scoreboard bench for io_flag_controller with a 4-deep FIFO and a 16-cycle output timeout.
module tb_io_flag_controller;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_INP  = 5'b10000;
  localparam logic [4:0] S_OUT  = 5'b01000;
  localparam logic [4:0] S_ION  = 5'b00100;
  localparam logic [4:0] S_IOF  = 5'b00010;
  localparam logic [4:0] S_ACK  = 5'b00001;

  logic       clock = 1'b0;
  logic       clr_n;
  logic [7:0] kbd_data;
  logic       kbd_arrived, vga_went;
  logic       cpu_inp, cpu_out, cpu_ion, cpu_iof, cpu_int_ack;
  logic [7:0] cpu_ac;
  logic [7:0] inpr, outr;
  logic       fgi, fgo, ien, int_req;
  logic [2:0] err_flags;

  typedef struct packed {
    logic [7:0] inpr;
    logic [7:0] outr;
    logic       fgi;
    logic       fgo;
    logic       ien;
    logic       int_req;
    logic [2:0] err;
  } obs_t;

  typedef struct {
    string      name;
    logic       arr;
    logic [7:0] data;
    logic       went;
    logic [4:0] strb;
    logic [7:0] ac;
    obs_t       exp;
    obs_t       msk;
  } vec_t;

  typedef struct {
    string name;
    obs_t  exp;
    obs_t  msk;
  } sb_t;

  vec_t vq[$];
  sb_t  sb[$];
  int   total = 0;
  int   bad   = 0;

  io_flag_controller #(
    .FIFO_DEPTH  (4),
    .OUT_TIMEOUT (16)
  ) dut (
    .clock       (clock),
    .clr_n       (clr_n),
    .kbd_data    (kbd_data),
    .kbd_arrived (kbd_arrived),
    .vga_went    (vga_went),
    .cpu_inp     (cpu_inp),
    .cpu_out     (cpu_out),
    .cpu_ion     (cpu_ion),
    .cpu_iof     (cpu_iof),
    .cpu_int_ack (cpu_int_ack),
    .cpu_ac      (cpu_ac),
    .inpr        (inpr),
    .outr        (outr),
    .fgi         (fgi),
    .fgo         (fgo),
    .ien         (ien),
    .int_req     (int_req),
    .err_flags   (err_flags)
  );

  always #5 clock = ~clock;

  function automatic obs_t o(logic [7:0] i, logic [7:0] r, logic fi, logic fo,
                             logic ie, logic rq, logic [2:0] e);
    obs_t x;
    x.inpr = i; x.outr = r; x.fgi = fi; x.fgo = fo; x.ien = ie; x.int_req = rq; x.err = e;
    return x;
  endfunction

  function automatic obs_t m(bit mi, bit mr, bit mfi, bit mfo, bit mie, bit mrq, bit me);
    obs_t x;
    x.inpr = {8{mi}}; x.outr = {8{mr}}; x.fgi = mfi; x.fgo = mfo;
    x.ien = mie; x.int_req = mrq; x.err = {3{me}};
    return x;
  endfunction

  task automatic add(string n, logic arr, logic [7:0] d, logic w, logic [4:0] strb,
                     logic [7:0] ac, obs_t e, obs_t k);
    vec_t v;
    v.name = n; v.arr = arr; v.data = d; v.went = w; v.strb = strb; v.ac = ac;
    v.exp = e; v.msk = k;
    vq.push_back(v);
  endtask

  task automatic check();
    obs_t act;
    sb_t  s;
    act = o(inpr, outr, fgi, fgo, ien, int_req, err_flags);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got %h", act);
      return;
    end
    s = sb.pop_front();
    if (s.msk == '0) return;
    total++;
    if (((act ^ s.exp) & s.msk) !== '0) begin
      bad++;
      $display("FAIL %s: got %h expected %h (mask %h)", s.name, act, s.exp, s.msk);
    end
  endtask

  task automatic clear_strobes();
    cpu_inp = 1'b0; cpu_out = 1'b0; cpu_ion = 1'b0; cpu_iof = 1'b0; cpu_int_ack = 1'b0;
  endtask

  // Each vector: drive at negedge, expectation queued, one posedge, compare at next negedge
  task automatic run_vecs();
    while (vq.size() > 0) begin
      vec_t v;
      sb_t  s;
      v = vq.pop_front();
      kbd_arrived = v.arr;
      kbd_data    = v.data;
      vga_went    = v.went;
      {cpu_inp, cpu_out, cpu_ion, cpu_iof, cpu_int_ack} = v.strb;
      cpu_ac      = v.ac;
      s.name = v.name; s.exp = v.exp; s.msk = v.msk;
      sb.push_back(s);
      @(negedge clock);
      check();
    end
    clear_strobes();
  endtask

  task automatic do_reset(string n);
    sb_t s;
    clear_strobes();
    kbd_arrived = 1'b0;
    vga_went    = 1'b0;
    clr_n       = 1'b0;
    #1;
    s.name = n; s.exp = o(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000); s.msk = '1;
    sb.push_back(s);
    check();
    @(negedge clock);
    clr_n = 1'b1;
  endtask

  // Keystroke: three cycles high (push on the third edge), two low
  task automatic key(string n, logic [7:0] d, logic pop, obs_t e, obs_t k);
    add({n, "_s1"}, 1'b1, d, 1'b0, S_NONE, 8'h00, '0, '0);
    add({n, "_s2"}, 1'b1, d, 1'b0, S_NONE, 8'h00, '0, '0);
    add(n, 1'b1, d, 1'b0, pop ? S_INP : S_NONE, 8'h00, e, k);
    add({n, "_l1"}, 1'b0, d, 1'b0, S_NONE, 8'h00, '0, '0);
    add({n, "_l2"}, 1'b0, d, 1'b0, S_NONE, 8'h00, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t rst_o;
    obs_t all_m;
    obs_t fifo_m;
    obs_t out_m;
    obs_t irq_m;
    rst_o  = o(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    all_m  = '1;
    fifo_m = m(1, 0, 1, 0, 0, 0, 1);
    out_m  = m(0, 1, 1, 1, 1, 1, 1);
    irq_m  = m(0, 0, 0, 1, 1, 1, 0);

    clr_n = 1'b1; kbd_data = 8'h00; kbd_arrived = 1'b0; vga_went = 1'b0; cpu_ac = 8'h00;
    clear_strobes();
    #2;
    do_reset("reset_state");

    // Single keystroke, held level, consume
    add("t1_idle",    1'b0, 8'h41, 1'b0, S_NONE, 8'h00, rst_o, all_m);
    add("t1_sync1",   1'b1, 8'h41, 1'b0, S_NONE, 8'h00, rst_o, m(0, 0, 1, 0, 0, 0, 0));
    add("t1_sync2",   1'b1, 8'h41, 1'b0, S_NONE, 8'h00, rst_o, m(0, 0, 1, 0, 0, 0, 0));
    add("t1_push",    1'b1, 8'h41, 1'b0, S_NONE, 8'h00, o(8'h41, 8'h00, 1, 1, 0, 0, 3'b000), all_m);
    add("t1_hold",    1'b1, 8'h41, 1'b0, S_NONE, 8'h00, o(8'h41, 8'h00, 1, 1, 0, 0, 3'b000), all_m);
    add("t1_pop",     1'b1, 8'h41, 1'b0, S_INP,  8'h00, rst_o, m(0, 1, 1, 1, 1, 1, 1));
    add("t1_release", 1'b0, 8'h41, 1'b0, S_NONE, 8'h00, rst_o, m(0, 1, 1, 1, 1, 1, 1));
    run_vecs();

    // Five keystrokes into four entries, then drain
    for (int i = 1; i <= 5; i++) begin
      key($sformatf("t2_key%0d", i), 8'(i), 1'b0,
          o(8'h01, 8'h00, 1, 1, 0, 0, (i == 5) ? 3'b001 : 3'b000), fifo_m);
    end
    for (int i = 2; i <= 4; i++) begin
      add($sformatf("t2_pop_to_%0d", i), 1'b0, 8'h00, 1'b0, S_INP, 8'h00,
          o(8'(i), 8'h00, 1, 1, 0, 0, 3'b001), fifo_m);
    end
    add("t2_pop_last", 1'b0, 8'h00, 1'b0, S_INP, 8'h00,
        o(8'h00, 8'h00, 0, 1, 0, 0, 3'b001), m(0, 0, 1, 0, 0, 0, 1));
    add("t2_pop_empty", 1'b0, 8'h00, 1'b0, S_INP, 8'h00,
        o(8'h00, 8'h00, 0, 1, 0, 0, 3'b001), m(0, 0, 1, 0, 0, 0, 1));
    run_vecs();

    // Push and pop together while full
    do_reset("t3_reset");
    for (int i = 0; i < 4; i++) begin
      key($sformatf("t3_fill%0d", i), 8'h11 + 8'(i), 1'b0, o(8'h11, 8'h00, 1, 1, 0, 0, 3'b000), fifo_m);
    end
    key("t3_pushpop", 8'h15, 1'b1, o(8'h12, 8'h00, 1, 1, 0, 0, 3'b000), fifo_m);
    for (int i = 3; i <= 5; i++) begin
      add($sformatf("t3_pop_to_1%0d", i), 1'b0, 8'h00, 1'b0, S_INP, 8'h00,
          o(8'h10 + 8'(i), 8'h00, 1, 1, 0, 0, 3'b000), fifo_m);
    end
    add("t3_pop_last", 1'b0, 8'h00, 1'b0, S_INP, 8'h00,
        o(8'h00, 8'h00, 0, 1, 0, 0, 3'b000), m(0, 0, 1, 0, 0, 0, 1));
    run_vecs();

    // Output handshake with a second OUT while busy
    do_reset("t4_reset");
    add("t4_out",       1'b0, 8'h00, 1'b0, S_OUT,  8'h5A, o(8'h00, 8'h5A, 0, 0, 0, 0, 3'b000), out_m);
    add("t4_out_busy",  1'b0, 8'h00, 1'b0, S_OUT,  8'hFF, o(8'h00, 8'h5A, 0, 0, 0, 0, 3'b010), out_m);
    add("t4_went1",     1'b0, 8'h00, 1'b1, S_NONE, 8'h00, o(8'h00, 8'h5A, 0, 0, 0, 0, 3'b010), out_m);
    add("t4_went2",     1'b0, 8'h00, 1'b1, S_NONE, 8'h00, o(8'h00, 8'h5A, 0, 0, 0, 0, 3'b010), out_m);
    add("t4_went3",     1'b0, 8'h00, 1'b1, S_NONE, 8'h00, o(8'h00, 8'h5A, 0, 1, 0, 0, 3'b010), out_m);
    add("t4_went_hold", 1'b0, 8'h00, 1'b1, S_NONE, 8'h00, o(8'h00, 8'h5A, 0, 1, 0, 0, 3'b010), out_m);
    run_vecs();

    // went_evt landing on the timeout cycle, then a real timeout
    do_reset("t5_reset");
    add("t5a_out", 1'b0, 8'h00, 1'b0, S_OUT, 8'h33, o(8'h00, 8'h33, 0, 0, 0, 0, 3'b000), out_m);
    for (int j = 1; j <= 16; j++) begin
      add($sformatf("t5a_cyc%0d", j), 1'b0, 8'h00, (j >= 14), S_NONE, 8'h00,
          o(8'h00, 8'h33, 0, (j == 16), 0, 0, 3'b000), out_m);
    end
    add("t5a_low1", 1'b0, 8'h00, 1'b0, S_NONE, 8'h00, o(8'h00, 8'h33, 0, 1, 0, 0, 3'b000), out_m);
    add("t5a_low2", 1'b0, 8'h00, 1'b0, S_NONE, 8'h00, o(8'h00, 8'h33, 0, 1, 0, 0, 3'b000), out_m);
    add("t5b_out",  1'b0, 8'h00, 1'b0, S_OUT,  8'h44, o(8'h00, 8'h44, 0, 0, 0, 0, 3'b000), out_m);
    for (int j = 1; j <= 16; j++) begin
      add($sformatf("t5b_cyc%0d", j), 1'b0, 8'h00, 1'b0, S_NONE, 8'h00,
          o(8'h00, 8'h44, 0, (j == 16), 0, 0, (j == 16) ? 3'b100 : 3'b000), out_m);
    end
    for (int j = 1; j <= 3; j++) begin
      add($sformatf("t5c_idle_went%0d", j), 1'b0, 8'h00, 1'b1, S_NONE, 8'h00,
          o(8'h00, 8'h44, 0, 1, 0, 0, 3'b100), out_m);
    end
    add("t5c_out_after", 1'b0, 8'h00, 1'b1, S_OUT, 8'h55, o(8'h00, 8'h55, 0, 0, 0, 0, 3'b100), out_m);
    run_vecs();

    // IEN set/clear priority and registered interrupt request
    do_reset("t6_reset");
    add("t6_ion",     1'b0, 8'h00, 1'b0, S_ION,         8'h00, o(0, 0, 0, 1, 1, 0, 0), irq_m);
    add("t6_irq",     1'b0, 8'h00, 1'b0, S_NONE,        8'h00, o(0, 0, 0, 1, 1, 1, 0), irq_m);
    add("t6_ion_iof", 1'b0, 8'h00, 1'b0, S_ION | S_IOF, 8'h00, o(0, 0, 0, 1, 0, 0, 0), irq_m);
    add("t6_off",     1'b0, 8'h00, 1'b0, S_NONE,        8'h00, o(0, 0, 0, 1, 0, 0, 0), irq_m);
    add("t6_ion2",    1'b0, 8'h00, 1'b0, S_ION,         8'h00, o(0, 0, 0, 1, 1, 0, 0), irq_m);
    add("t6_irq2",    1'b0, 8'h00, 1'b0, S_NONE,        8'h00, o(0, 0, 0, 1, 1, 1, 0), irq_m);
    add("t6_ack",     1'b0, 8'h00, 1'b0, S_ACK,         8'h00, o(0, 0, 0, 1, 0, 0, 0), irq_m);
    run_vecs();

    // Reset asserted in the middle of a busy output with state everywhere
    key("t7_key", 8'h77, 1'b0, o(8'h77, 8'h00, 1, 1, 0, 0, 3'b000), all_m);
    add("t7_ion",  1'b0, 8'h00, 1'b0, S_ION,  8'h00, o(8'h77, 8'h00, 1, 1, 1, 0, 3'b000), all_m);
    add("t7_out",  1'b0, 8'h00, 1'b0, S_OUT,  8'h99, o(8'h77, 8'h99, 1, 0, 1, 1, 3'b000), all_m);
    add("t7_busy", 1'b0, 8'h00, 1'b0, S_NONE, 8'h00, o(8'h77, 8'h99, 1, 0, 1, 1, 3'b000), all_m);
    run_vecs();
    do_reset("t7_midbusy_reset");
    add("t7_after", 1'b0, 8'h00, 1'b0, S_NONE, 8'h00, rst_o, all_m);
    run_vecs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
